// File: rtl/station_ctrl.sv
// station_ctrl: station-to-station transit controller with an optional obstacle buzzer.
// Latency: command/ID acknowledges are combinational; state changes take effect at the next clk edge.
// Buzzer logic is compiled only when STATION_CTRL_BUZZ_EN is defined; otherwise buzz=0 and buzz_n=1.
module station_ctrl #(
   parameter int BUZZ_HALF = 6250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd,
   input  logic        cmd_rdy,
   output logic        clr_cmd_rdy,
   input  logic [7:0]  ID,
   input  logic        ID_vld,
   output logic        clr_ID_vld,
   input  logic        OK2Move,
   output logic        in_transit,
   output logic        go,
   output logic        buzz,
   output logic        buzz_n
);

   typedef enum logic {IDLE, TRANSIT} state_t;

   state_t     state;
   logic [5:0] dest;

   logic is_go;
   logic is_stop;
   logic take_cmd;
   logic take_id;
   logic id_hit;

   // Opcode decode; 2'b10/2'b11 fall through as acknowledged no-ops.
   assign is_go   = (cmd[15:14] == 2'b01);
   assign is_stop = (cmd[15:14] == 2'b00);

   // A pending command always wins the cycle; the ID waits until cmd_rdy drops.
   // Acks are gated by rst_n so nothing is acknowledged while held in reset.
   assign take_cmd = rst_n & cmd_rdy;
   assign take_id  = rst_n & ID_vld & ~cmd_rdy;

   // Only the low six bits of a station ID name a destination.
   assign id_hit = (ID[5:0] == dest);

   assign clr_cmd_rdy = take_cmd;
   assign clr_ID_vld  = take_id;

   assign in_transit = (state == TRANSIT);
   assign go         = in_transit & OK2Move;

   // ID[7:6] and the unused command field are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{ID[7:6], cmd[13:6]};

   // Transit FSM: GO (re)targets dest and travels, STOP or reaching dest returns to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         dest  <= 6'h00;
      end else if (take_cmd) begin
         if (is_go) begin
            dest  <= cmd[5:0];
            state <= TRANSIT;
         end else if (is_stop) begin
            state <= IDLE;
         end
      end else if (take_id && (state == TRANSIT) && id_hit) begin
         state <= IDLE;
      end
   end

`ifdef STATION_CTRL_BUZZ_EN
   localparam int CW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;

   logic [CW-1:0] buzz_cnt;
   logic          buzz_act;
   logic          buzz_q;

   // Sound only while we want to move but the path is blocked.
   assign buzz_act = in_transit & ~OK2Move;

   // Half-period counter; held at zero and output silenced whenever inactive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buzz_cnt <= '0;
         buzz_q   <= 1'b0;
      end else if (!buzz_act) begin
         buzz_cnt <= '0;
         buzz_q   <= 1'b0;
      end else if (buzz_cnt == CW'(BUZZ_HALF - 1)) begin
         buzz_cnt <= '0;
         buzz_q   <= ~buzz_q;
      end else begin
         buzz_cnt <= buzz_cnt + CW'(1);
      end
   end

   assign buzz   = buzz_q;
   assign buzz_n = ~buzz_q;
`else
   logic unused_param;
   assign unused_param = (BUZZ_HALF != 0);

   assign buzz   = 1'b0;
   assign buzz_n = 1'b1;
`endif

endmodule

// File: doc/station_ctrl.md
STATION_CTRL -- requirements
Module: station_ctrl

Interface
REQ-001 SHALL have parameter BUZZ_HALF, default 6250, clk cycles per buzzer half-period (4 kHz at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd  input  16  command word; valid while cmd_rdy high.
REQ-005 SHALL have port cmd_rdy  input  1  command present; held until clr_cmd_rdy.
REQ-006 SHALL have port clr_cmd_rdy  output  1  one-cycle pulse acknowledging cmd.
REQ-007 SHALL have port ID  input  8  station ID from barcode reader.
REQ-008 SHALL have port ID_vld  input  1  ID valid; held until clr_ID_vld.
REQ-009 SHALL have port clr_ID_vld  output  1  one-cycle pulse acknowledging ID.
REQ-010 SHALL have port OK2Move  input  1  obstacle-free indication; high = path clear.
REQ-011 SHALL have port in_transit  output  1  registered; high while travelling to destination.
REQ-012 SHALL have port go  output  1  motion enable = in_transit AND OK2Move, combinational.
REQ-013 SHALL have port buzz  output  1  piezo drive.
REQ-014 SHALL have port buzz_n  output  1  complement of buzz.

Function
REQ-015 SHALL decode cmd[15:14]: 2'b01 = GO with destination cmd[5:0]; 2'b00 = STOP; 2'b10/2'b11 = ignored (acknowledged, no effect).
REQ-016 SHALL implement two states, IDLE and TRANSIT; in_transit is high exactly when state is TRANSIT.
REQ-017 SHALL assert clr_cmd_rdy combinationally for one cycle in any cycle where cmd_rdy is high and a command is consumed, in either state.
REQ-018 SHALL, in IDLE on GO, latch cmd[5:0] into 6-bit dest register and enter TRANSIT at the next edge.
REQ-019 SHALL, in IDLE on STOP or an ignored opcode, remain in IDLE.
REQ-020 SHALL, in IDLE with ID_vld high and no cmd_rdy, pulse clr_ID_vld and discard ID (stale station).
REQ-021 SHALL, in TRANSIT on GO, overwrite dest with cmd[5:0] and remain in TRANSIT.
REQ-022 SHALL, in TRANSIT on STOP, return to IDLE at the next edge.
REQ-023 SHALL, in TRANSIT with ID_vld high and no cmd_rdy, pulse clr_ID_vld; if ID[5:0] == dest, enter IDLE at next edge, else remain in TRANSIT.
REQ-024 SHALL give cmd_rdy priority when cmd_rdy and ID_vld are both high: only clr_cmd_rdy pulses; ID_vld is serviced the following cycle against the updated dest.
REQ-025 SHALL never assert clr_cmd_rdy and clr_ID_vld in the same cycle.
REQ-026 SHALL ignore ID[7:6] when comparing against dest.
REQ-027 SHALL update go in the same cycle OK2Move changes (no added latency).
REQ-028 SHALL, when buzzer is active, toggle buzz every BUZZ_HALF cycles using a counter that wraps from BUZZ_HALF-1 to 0.
REQ-029 SHALL make the buzzer active only while in_transit is high and OK2Move is low; when inactive, buzz = 0 and the counter is held at 0.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set state IDLE, dest 6'h00, buzzer counter 0, buzz 0.
REQ-031 SHALL hold in_transit=0, go=0, buzz_n=1, clr_cmd_rdy=0, clr_ID_vld=0 while rst_n is low.
REQ-032 SHALL abandon any in-progress transit on reset mid-operation; no pending command or ID is acknowledged.

Configuration
REQ-033 SHALL compile buzzer logic only when macro STATION_CTRL_BUZZ_EN is defined.
REQ-034 SHALL, with STATION_CTRL_BUZZ_EN defined, behave per REQ-028/029.
REQ-035 SHALL, without STATION_CTRL_BUZZ_EN, tie buzz to 0 and buzz_n to 1 and contain no buzzer counter; all other behaviour is unchanged.

Verification
REQ-036 SHALL cover: cmd=16'h4015 with cmd_rdy -> clr_cmd_rdy one pulse, in_transit=1 next cycle, go=1 while OK2Move=1.
REQ-037 SHALL cover: in TRANSIT to 0x15, ID=8'h07 then ID=8'h15 with ID_vld -> two clr_ID_vld pulses, in_transit stays 1 after 0x07, drops to 0 the cycle after 0x15.
REQ-038 SHALL cover: in TRANSIT, cmd=16'h0000 -> in_transit=0 next cycle, go=0.
REQ-039 SHALL cover: cmd_rdy (GO 0x22) and ID_vld (ID=8'h22) same cycle during TRANSIT to 0x15 -> clr_cmd_rdy first cycle, clr_ID_vld next cycle, in_transit=0 after.
REQ-040 SHALL cover: with STATION_CTRL_BUZZ_EN and BUZZ_HALF=4, in TRANSIT, OK2Move=0 for 20 cycles -> go=0, buzz toggles every 4 cycles, buzz_n=~buzz; OK2Move=1 -> buzz=0 next cycle.
REQ-041 SHALL cover: rst_n asserted mid-TRANSIT -> in_transit=0, go=0, buzz=0 immediately; cmd_rdy held high -> serviced in IDLE after release.
